// File: rtl/riscv_alu_pkg.sv
// Shared ALU/MDU definitions: ALUControl encodings for RV32M,
// datapath width and the MDU sequencer state encoding.
package riscv_alu_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 6;

  localparam logic [4:0] ALU_MUL    = 5'b10000;
  localparam logic [4:0] ALU_MULH   = 5'b10001;
  localparam logic [4:0] ALU_MULHSU = 5'b10010;
  localparam logic [4:0] ALU_MULHU  = 5'b10011;
  localparam logic [4:0] ALU_DIV    = 5'b10100;
  localparam logic [4:0] ALU_DIVU   = 5'b10101;
  localparam logic [4:0] ALU_REM    = 5'b10110;
  localparam logic [4:0] ALU_REMU   = 5'b10111;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_CALC = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_e;

  function automatic logic [XLEN-1:0] neg_if(
    input logic            n,
    input logic [XLEN-1:0] v
  );
    return n ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/mdu_div_core.sv
// One restoring-divide step on unsigned magnitudes.
// Ports: rem_i/quo_i/dvsr_i in, rem_o/quo_o out (combinational).
module mdu_div_core #(
  parameter int W = 32
) (
  input  logic [W:0]   rem_i,
  input  logic [W-1:0] quo_i,
  input  logic [W-1:0] dvsr_i,
  output logic [W:0]   rem_o,
  output logic [W-1:0] quo_o
);

  logic [W:0] shifted;
  logic [W:0] diff;
  logic       ge;
  logic       unused;

  // Partial remainder stays below the divisor, so its top bit is spare.
  assign unused  = rem_i[W];
  assign shifted = {rem_i[W-1:0], quo_i[W-1]};
  assign diff    = shifted - {1'b0, dvsr_i};
  assign ge      = shifted >= {1'b0, dvsr_i};
  assign rem_o   = ge ? diff : shifted;
  assign quo_o   = {quo_i[W-2:0], ge};

endmodule

// File: rtl/mdu_sequencer.sv
// RV32M multi-cycle sequencer: shift-add multiply, restoring divide.
// Ports: clk, rst_n, op_valid/op_code/rs1_val/rs2_val/rd_addr, flush
//   in; busy, res_valid, result, res_rd out. MDU_FAST_MUL_EN: 1-cycle mul.
module mdu_sequencer #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            op_valid,
  input  logic [4:0]      op_code,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd_addr,
  input  logic            flush,
  output logic            busy,
  output logic            res_valid,
  output logic [XLEN-1:0] result,
  output logic [4:0]      res_rd
);

  import riscv_alu_pkg::mdu_state_e;
  import riscv_alu_pkg::MDU_IDLE;
  import riscv_alu_pkg::MDU_CALC;
  import riscv_alu_pkg::MDU_DONE;
  import riscv_alu_pkg::ALU_MUL;
  import riscv_alu_pkg::ALU_MULH;
  import riscv_alu_pkg::ALU_MULHSU;
  import riscv_alu_pkg::neg_if;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  MINV = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        f3_q;
  logic [4:0]        rd_q;
  logic [XLEN-1:0]   a_q;
  logic [XLEN-1:0]   b_q;
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN:0]     rem_q;
  logic              neg_q;
  logic              nega_q;
  logic [XLEN-1:0]   res_q;
  logic [4:0]        res_rd_q;

  logic [2:0]        f3;
  logic              is_div;
  logic              sa;
  logic              sb;
  logic              neg_a;
  logic              neg_b;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic              accept;
  logic              dz;
  logic              ovf;
  logic [XLEN-1:0]   early_res;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_acc;
  logic [2*XLEN-1:0] prod;
  logic [XLEN:0]     div_rem;
  logic [XLEN-1:0]   div_quo;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   fin_res;
  logic              unused;

  assign f3     = op_code[2:0];
  assign is_div = f3[2];
  // rs1 is signed for MUL/MULH/MULHSU/DIV/REM; rs2 drops MULHSU.
  assign sa     = ~f3[0] | (f3 == ALU_MULH[2:0]);
  assign sb     = sa & (f3 != ALU_MULHSU[2:0]);
  assign neg_a  = sa & rs1_val[XLEN-1];
  assign neg_b  = sb & rs2_val[XLEN-1];
  assign mag_a  = neg_if(neg_a, rs1_val);
  assign mag_b  = neg_if(neg_b, rs2_val);

  assign accept = (state_q == MDU_IDLE) & op_valid
                & op_code[4] & ~flush;
  assign dz     = is_div & (rs2_val == '0);
  assign ovf    = is_div & sa & (rs1_val == MINV)
                & (rs2_val == '1);

  // f3[1] selects remainder over quotient for the divide family.
  always_comb begin
    early_res = '0;
    if (dz) early_res = f3[1] ? rs1_val : '1;
    else    early_res = f3[1] ? '0 : MINV;
  end

  assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]}
                 + {1'b0, (acc_q[0] ? a_q : '0)};
  assign mul_acc = {mul_sum, acc_q[XLEN-1:1]};
  assign prod    = neg_q ? (~mul_acc + 1'b1) : mul_acc;

  mdu_div_core #(.W(XLEN)) u_div (
    .rem_i  (rem_q),
    .quo_i  (acc_q[XLEN-1:0]),
    .dvsr_i (b_q),
    .rem_o  (div_rem),
    .quo_o  (div_quo)
  );

  assign quo_fix = neg_if(neg_q, div_quo);
  assign rem_fix = neg_if(nega_q, div_rem[XLEN-1:0]);

  always_comb begin
    fin_res = '0;
    if (f3_q[2])                   fin_res = f3_q[1] ? rem_fix : quo_fix;
    else if (f3_q == ALU_MUL[2:0]) fin_res = prod[XLEN-1:0];
    else                           fin_res = prod[2*XLEN-1:XLEN];
  end

`ifdef MDU_FAST_MUL_EN
  logic signed [2*XLEN+1:0] fa;
  logic signed [2*XLEN+1:0] fb;
  logic signed [2*XLEN+1:0] fprod;
  logic        [XLEN-1:0]   fast_res;

  assign fa       = (2*XLEN+2)'($signed({neg_a, rs1_val}));
  assign fb       = (2*XLEN+2)'($signed({neg_b, rs2_val}));
  assign fprod    = fa * fb;
  assign fast_res = (f3 == ALU_MUL[2:0]) ? fprod[XLEN-1:0]
                                         : fprod[2*XLEN-1:XLEN];
  assign unused   = ^{op_code[3], rem_q[XLEN], fprod[2*XLEN+1:2*XLEN]};
`else
  assign unused   = ^{op_code[3], rem_q[XLEN]};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= MDU_IDLE;
      cnt_q    <= '0;
      f3_q     <= '0;
      rd_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      neg_q    <= 1'b0;
      nega_q   <= 1'b0;
      res_q    <= '0;
      res_rd_q <= '0;
    end else begin
      unique case (state_q)
        MDU_IDLE: begin
          if (accept) begin
            f3_q   <= f3;
            rd_q   <= rd_addr;
            a_q    <= mag_a;
            b_q    <= mag_b;
            neg_q  <= neg_a ^ neg_b;
            nega_q <= neg_a;
            cnt_q  <= '0;
            rem_q  <= '0;
            acc_q  <= {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
            if (dz | ovf) begin
              res_q    <= early_res;
              res_rd_q <= rd_addr;
              state_q  <= MDU_DONE;
            end
`ifdef MDU_FAST_MUL_EN
            else if (!is_div) begin
              res_q    <= fast_res;
              res_rd_q <= rd_addr;
              state_q  <= MDU_DONE;
            end
`endif
            else begin
              state_q <= MDU_CALC;
            end
          end
        end
        MDU_CALC: begin
          if (flush) begin
            state_q <= MDU_IDLE;
          end else begin
            if (f3_q[2]) begin
              rem_q           <= div_rem;
              acc_q[XLEN-1:0] <= div_quo;
            end else begin
              acc_q <= mul_acc;
            end
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST) begin
              res_q    <= fin_res;
              res_rd_q <= rd_q;
              state_q  <= MDU_DONE;
            end
          end
        end
        MDU_DONE: state_q <= MDU_IDLE;
        default:  state_q <= MDU_IDLE;
      endcase
    end
  end

  assign busy      = accept | (state_q == MDU_CALC);
  assign res_valid = (state_q == MDU_DONE) & ~flush;
  assign result    = res_q;
  assign res_rd    = res_rd_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Scoreboard bench for mdu_sequencer: results, latency, flush,
// reset abort, back-to-back ops and non-M ops.
`timescale 1ns/1ps
module tb_mdu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        op_valid = 1'b0;
  logic [4:0]  op_code = '0;
  logic [31:0] rs1_val = '0;
  logic [31:0] rs2_val = '0;
  logic [4:0]  rd_addr = '0;
  logic        flush = 1'b0;
  logic        busy;
  logic        res_valid;
  logic [31:0] result;
  logic [4:0]  res_rd;

  mdu_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op_valid  (op_valid),
    .op_code   (op_code),
    .rs1_val   (rs1_val),
    .rs2_val   (rs2_val),
    .rd_addr   (rd_addr),
    .flush     (flush),
    .busy      (busy),
    .res_valid (res_valid),
    .result    (result),
    .res_rd    (res_rd)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
  } exp_t;

  exp_t exp_q[$];
  int passed = 0;
  int total  = 0;

`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 34;
`endif

  localparam logic [4:0] OP_MUL    = 5'b10000;
  localparam logic [4:0] OP_MULH   = 5'b10001;
  localparam logic [4:0] OP_MULHSU = 5'b10010;
  localparam logic [4:0] OP_MULHU  = 5'b10011;
  localparam logic [4:0] OP_DIV    = 5'b10100;
  localparam logic [4:0] OP_DIVU   = 5'b10101;
  localparam logic [4:0] OP_REM    = 5'b10110;
  localparam logic [4:0] OP_REMU   = 5'b10111;

  function automatic logic [31:0] model(
    input logic [4:0] op, input logic [31:0] a, input logic [31:0] b
  );
    longint      sa, sb, ub, p;
    logic [63:0] up;
    logic        ov;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    ov = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op[2:0])
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ov) return 32'h8000_0000;
        return $signed(a) / $signed(b);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ov) return 32'h0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Presents one op for a single cycle and waits for the result pulse.
  task automatic run_op(
    input  logic [4:0]  op, input logic [31:0] a, input logic [31:0] b,
    input  logic [4:0]  rd,
    output logic [31:0] res, output logic [4:0] rrd,
    output int lat, output int bcnt
  );
    op_valid = 1'b1; op_code = op;
    rs1_val = a; rs2_val = b; rd_addr = rd;
    lat = 0; bcnt = 0; res = '0; rrd = '0;
    for (int c = 1; c <= 60 && lat == 0; c++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (res_valid) begin lat = c; res = result; rrd = res_rd; end
      @(posedge clk); #1;
      op_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    #12;
    total++;
    if ({busy, res_valid} !== 2'b00) begin
      $display("FAIL reset_flags got=%b want=00", {busy, res_valid});
    end else passed++;
    total++;
    if (result !== 32'h0 || res_rd !== 5'h0) begin
      $display("FAIL reset_regs got=%h/%h want=0/0", result, res_rd);
    end else passed++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_div_latency();
    logic [31:0] r; logic [4:0] d; int lat, bc; exp_t e;
    exp_q.push_back('{res: 32'd14, rd: 5'd9});
    run_op(OP_DIV, 32'd100, 32'd7, 5'd9, r, d, lat, bc);
    e = exp_q.pop_front();
    total++;
    if (r !== e.res) $display("FAIL div100_7 got=%h want=%h", r, e.res);
    else passed++;
    total++;
    if (d !== e.rd) $display("FAIL div_rd got=%0d want=%0d", d, e.rd);
    else passed++;
    total++;
    if (lat !== 34) $display("FAIL div_latency got=%0d want=34", lat);
    else passed++;
    total++;
    if (bc !== 33) $display("FAIL div_busy_cycles got=%0d want=33", bc);
    else passed++;
    @(negedge clk);
    total++;
    if (res_valid !== 1'b0) $display("FAIL div_pulse_len got=1 want=0");
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_div_special();
    logic [31:0] r; logic [4:0] d; int lat, bc; exp_t e;
    exp_q.push_back('{res: 32'hFFFF_FFFE, rd: 5'd1});
    run_op(OP_REM, 32'hFFFF_FF9C, 32'd7, 5'd1, r, d, lat, bc);
    e = exp_q.pop_front();
    total++;
    if (r !== e.res) $display("FAIL rem_neg got=%h want=%h", r, e.res);
    else passed++;

    exp_q.push_back('{res: 32'hFFFF_FFFF, rd: 5'd2});
    run_op(OP_DIVU, 32'd5, 32'd0, 5'd2, r, d, lat, bc);
    e = exp_q.pop_front();
    total++;
    if (r !== e.res) $display("FAIL divu_by0 got=%h want=%h", r, e.res);
    else passed++;
    total++;
    if (lat !== 2) $display("FAIL divu_by0_lat got=%0d want=2", lat);
    else passed++;

    exp_q.push_back('{res: 32'h1234_5678, rd: 5'd3});
    run_op(OP_REMU, 32'h1234_5678, 32'd0, 5'd3, r, d, lat, bc);
    e = exp_q.pop_front();
    total++;
    if (r !== e.res) $display("FAIL remu_by0 got=%h want=%h", r, e.res);
    else passed++;

    exp_q.push_back('{res: 32'h8000_0000, rd: 5'd4});
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, r, d, lat, bc);
    e = exp_q.pop_front();
    total++;
    if (r !== e.res || lat !== 2) begin
      $display("FAIL div_ovf got=%h/%0d want=%h/2", r, lat, e.res);
    end else passed++;

    exp_q.push_back('{res: 32'h0, rd: 5'd5});
    run_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd5, r, d, lat, bc);
    e = exp_q.pop_front();
    total++;
    if (r !== e.res) $display("FAIL rem_ovf got=%h want=%h", r, e.res);
    else passed++;
  endtask

  task automatic test_mul();
    logic [31:0] r; logic [4:0] d; int lat, bc; exp_t e;
    logic [4:0]  ops [4];
    logic [31:0] as  [4];
    logic [31:0] bs  [4];
    logic [31:0] ws  [4];
    ops[0] = OP_MULH;   as[0] = '1; bs[0] = '1; ws[0] = 32'h0;
    ops[1] = OP_MULHU;  as[1] = '1; bs[1] = '1; ws[1] = 32'hFFFF_FFFE;
    ops[2] = OP_MULHSU; as[2] = '1; bs[2] = '1; ws[2] = 32'hFFFF_FFFF;
    ops[3] = OP_MUL;    as[3] = 32'd7; bs[3] = 32'hFFFF_FFFD;
    ws[3] = 32'hFFFF_FFEB;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back('{res: ws[i], rd: 5'(10 + i)});
      run_op(ops[i], as[i], bs[i], 5'(10 + i), r, d, lat, bc);
      e = exp_q.pop_front();
      total++;
      if (r !== e.res || d !== e.rd) begin
        $display("FAIL mul_%0d got=%h/%0d want=%h/%0d",
                 i, r, d, e.res, e.rd);
      end else passed++;
    end
    total++;
    if (lat !== MUL_LAT) begin
      $display("FAIL mul_latency got=%0d want=%0d", lat, MUL_LAT);
    end else passed++;
  endtask

  task automatic test_flush();
    logic [31:0] r; logic [4:0] d; int lat, bc, pulses; exp_t e;
    op_valid = 1'b1; op_code = OP_DIV;
    rs1_val = 32'd1000; rs2_val = 32'd3; rd_addr = 5'd7;
    @(posedge clk); #1;
    op_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) $display("FAIL flush_busy got=%b want=0", busy);
    else passed++;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (res_valid) pulses++;
    end
    total++;
    if (pulses !== 0) $display("FAIL flush_novalid got=%0d want=0", pulses);
    else passed++;
    @(posedge clk); #1;

    exp_q.push_back('{res: 32'd4, rd: 5'd8});
    run_op(OP_DIVU, 32'd9, 32'd2, 5'd8, r, d, lat, bc);
    e = exp_q.pop_front();
    total++;
    if (r !== e.res || d !== e.rd) begin
      $display("FAIL after_flush got=%h/%0d want=%h/%0d", r, d, e.res, e.rd);
    end else passed++;

    op_valid = 1'b1; op_code = OP_DIVU;
    rs1_val = 32'd5; rs2_val = 32'd0; rd_addr = 5'd6;
    @(posedge clk); #1;
    op_valid = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    total++;
    if (res_valid !== 1'b0) $display("FAIL flush_done got=1 want=0");
    else passed++;
    @(posedge clk); #1;
    flush = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int pulses;
    op_valid = 1'b1; op_code = OP_DIV;
    rs1_val = 32'd1000; rs2_val = 32'd3; rd_addr = 5'd12;
    @(posedge clk); #1;
    op_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({busy, res_valid} !== 2'b00) begin
      $display("FAIL rst_mid_flags got=%b want=00", {busy, res_valid});
    end else passed++;
    total++;
    if (result !== 32'h0) $display("FAIL rst_mid_result got=%h want=0", result);
    else passed++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (res_valid) pulses++;
    end
    total++;
    if (pulses !== 0) $display("FAIL rst_mid_pulse got=%0d want=0", pulses);
    else passed++;
    @(posedge clk); #1;
  endtask

  // EX holds the op while busy and advances once busy drops.
  task automatic test_back_to_back();
    logic [4:0]  ops [2];
    logic [31:0] as  [2];
    logic [31:0] bs  [2];
    logic [4:0]  rds [2];
    int idx, pulses;
    logic b;
    exp_t e;
    ops[0] = OP_MUL; as[0] = 32'd7;   bs[0] = 32'hFFFF_FFFD; rds[0] = 5'd3;
    ops[1] = OP_DIV; as[1] = 32'd100; bs[1] = 32'd7;         rds[1] = 5'd4;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back('{res: model(ops[i], as[i], bs[i]), rd: rds[i]});
    end
    idx = 0; pulses = 0;
    for (int c = 0; c < 120; c++) begin
      if (idx < 2) begin
        op_valid = 1'b1; op_code = ops[idx];
        rs1_val = as[idx]; rs2_val = bs[idx]; rd_addr = rds[idx];
      end else op_valid = 1'b0;
      @(negedge clk);
      b = busy;
      if (res_valid) begin
        pulses++;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          total++;
          if (result !== e.res || res_rd !== e.rd) begin
            $display("FAIL b2b_%0d got=%h/%0d want=%h/%0d",
                     pulses, result, res_rd, e.res, e.rd);
          end else passed++;
        end
      end
      @(posedge clk); #1;
      if (!b && idx < 2) idx++;
    end
    op_valid = 1'b0;
    total++;
    if (pulses !== 2) $display("FAIL b2b_pulses got=%0d want=2", pulses);
    else passed++;
    exp_q.delete();
  endtask

  task automatic test_non_mop();
    int hits;
    hits = 0;
    op_valid = 1'b1; op_code = 5'b00000;
    rs1_val = 32'd3; rs2_val = 32'd4; rd_addr = 5'd1;
    for (int c = 0; c < 6; c++) begin
      if (c == 3) op_code = 5'b01111;
      @(negedge clk);
      if (busy || res_valid) hits++;
      @(posedge clk); #1;
    end
    op_valid = 1'b0;
    total++;
    if (hits !== 0) $display("FAIL non_mop got=%0d want=0", hits);
    else passed++;
  endtask

  task automatic test_random();
    logic [31:0] r, a, b; logic [4:0] d, op; int lat, bc; exp_t e;
    for (int i = 0; i < 8; i++) begin
      op = {2'b10, 3'(i)};
      a  = $urandom;
      b  = (i == 7) ? 32'd0 : $urandom;
      if (i == 4) b = 32'd0 - 32'd13;
      exp_q.push_back('{res: model(op, a, b), rd: 5'(20 + i)});
      run_op(op, a, b, 5'(20 + i), r, d, lat, bc);
      e = exp_q.pop_front();
      total++;
      if (r !== e.res || d !== e.rd) begin
        $display("FAIL rand_op%0d a=%h b=%h got=%h/%0d want=%h/%0d",
                 i, a, b, r, d, e.res, e.rd);
      end else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_div_latency();
    test_div_special();
    test_mul();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    test_non_mop();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
